sum_sched: RTL and testbench

- Round-robin scheduler that shares one accumulate-until-zero datapath between NUM_REQ requesters.
- Each requester streams words over its own lane; a word of value zero terminates the stream.
- The block grants one requester at a time, accumulates that requester's words, and reports the total with the requester id.
- Sits between the requesting front-end units and the result consumer; the block holds the only accumulator.

---
 rtl/sum_sched_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/sum_sched.sv | 100 ++++++++++
 tb/tb_sum_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sum_sched_pkg.sv
// sum_sched_pkg: shared FSM state type, default sizes and id-width helper for sum_sched.
package sum_sched_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NUM_REQ = 4;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_id+1 with wrap.
module rr_arbiter import sum_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [NUM_REQ-1:0] gnt_next,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req
);
  // Walk candidates from furthest to nearest so the nearest requester is the last write.
  always_comb begin
    gnt_next = '0;
    gnt_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(last_id) + 1 + k) % NUM_REQ]) begin
        gnt_next = '0;
        gnt_next[(int'(last_id) + 1 + k) % NUM_REQ] = 1'b1;
        gnt_id = ID_W'((int'(last_id) + 1 + k) % NUM_REQ);
      end
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/sum_sched.sv
// sum_sched: round-robin shared accumulate-until-zero datapath; SUM_SCHED_OVF_EN adds a sticky ovf output.
module sum_sched import sum_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       valid,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       accept,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [WIDTH-1:0]         sum
`ifdef SUM_SCHED_OVF_EN
  , output logic                   ovf
`endif
);
  state_t state, state_nxt;
  logic [ID_W-1:0] last_id, cur_id, arb_id;
  logic [NUM_REQ-1:0] arb_gnt;
  logic any_req, fire;
  logic [WIDTH-1:0] acc, word;
`ifdef SUM_SCHED_OVF_EN
  logic ovf_acc;
  logic [WIDTH:0] add;
  assign add = {1'b0, acc} + {1'b0, word};
`else
  logic [WIDTH-1:0] add;
  assign add = acc + word;
`endif
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req),
    .last_id(last_id),
    .gnt_next(arb_gnt),
    .gnt_id(arb_id),
    .any_req(any_req)
  );
  assign word = data[int'(cur_id)*WIDTH +: WIDTH];
  assign fire = |accept;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = any_req ? ACCUM : IDLE;
      ACCUM:   state_nxt = (fire && word == '0) ? DONE : ACCUM;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    accept = (state == ACCUM) ? gnt & valid : '0;
  end
  // sum/done_id load on the zero word so they are already valid while done is high.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt <= '0;
      cur_id <= '0;
      last_id <= ID_W'(NUM_REQ - 1);
      acc <= '0;
      sum <= '0;
      done_id <= '0;
`ifdef SUM_SCHED_OVF_EN
      ovf_acc <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      if (state == IDLE && any_req) begin
        gnt <= arb_gnt;
        cur_id <= arb_id;
      end
      if (fire && word != '0) begin
        acc <= add[WIDTH-1:0];
`ifdef SUM_SCHED_OVF_EN
        ovf_acc <= ovf_acc | add[WIDTH];
`endif
      end
      if (fire && word == '0) begin
        sum <= acc;
        done_id <= cur_id;
        gnt <= '0;
`ifdef SUM_SCHED_OVF_EN
        ovf <= ovf_acc;
`endif
      end
      if (state == DONE) begin
        last_id <= cur_id;
        acc <= '0;
`ifdef SUM_SCHED_OVF_EN
        ovf_acc <= 1'b0;
`endif
      end
    end
endmodule

// File: tb/tb_sum_sched.sv
// tb_sum_sched: directed table and sequence checks for sum_sched (define SUM_SCHED_OVF_EN to cover ovf).
module tb_sum_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, valid = '0;
  logic [63:0] data = '0;
  logic [3:0] gnt, accept;
  logic busy, done;
  logic [1:0] done_id;
  logic [15:0] sum;
`ifdef SUM_SCHED_OVF_EN
  logic ovf;
`endif
  int checks = 0, errors = 0;

  sum_sched dut (
    .clk(clk), .rst(rst), .req(req), .valid(valid), .data(data),
    .gnt(gnt), .accept(accept), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum)
`ifdef SUM_SCHED_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req, valid;
    logic [63:0] d;
    logic [3:0] gnt, acc;
    logic busy, done;
    logic [1:0] id;
    logic [15:0] sum;
  } vec_t;
  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic send(input int id, input logic [15:0] w[4], input int n, input int gap,
                      input bit noise, input logic [15:0] es);
    logic [3:0] nv;
    logic [63:0] nd;
`ifdef SUM_SCHED_OVF_EN
    logic [16:0] t;
    logic eo;
    t = '0;
    eo = 1'b0;
    for (int k = 0; k < n; k++) begin
      t = {1'b0, t[15:0]} + {1'b0, w[k]};
      eo = eo | t[16];
    end
`endif
    nv = noise ? 4'b1000 : 4'b0000;
    nd = noise ? (64'd9 << 48) : 64'd0;
    req = 4'(1 << id);
    valid = nv;
    data = nd;
    tick();
    chk("xfer_gnt", gnt, 64'(1 << id));
    chk("xfer_busy", busy, 1);
    req = '0;
    for (int k = 0; k < n; k++) begin
      repeat (gap) begin
        valid = nv;
        data = nd;
        #1 chk("gap_accept", accept, 0);
        tick();
      end
      valid = nv | 4'(1 << id);
      data = nd | (64'(w[k]) << (16 * id));
      #1 chk("xfer_accept", accept, 64'(1 << id));
      tick();
    end
    valid = nv;
    data = nd;
    #1;
    chk("xfer_done", done, 1);
    chk("xfer_done_id", done_id, 64'(id));
    chk("xfer_done_gnt", gnt, 0);
    chk("xfer_sum", sum, es);
`ifdef SUM_SCHED_OVF_EN
    chk("xfer_ovf", ovf, eo);
`endif
    tick();
    chk("xfer_done_clear", done, 0);
    chk("xfer_idle_busy", busy, 0);
    valid = '0;
    data = '0;
  endtask

  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'd0};
    tbl[1] = '{4'b0000, 4'b0001, 64'd5, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[2] = '{4'b0000, 4'b0001, 64'd7, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[3] = '{4'b0000, 4'b0001, 64'd0, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 16'd0};
    tbl[4] = '{4'b0000, 4'b0000, 64'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 16'd12};
    tbl[5] = '{4'b0000, 4'b0000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'd12};
    tbl[6] = '{4'b0100, 4'b0100, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 16'd12};
    tbl[7] = '{4'b0000, 4'b0100, 64'd0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0, 16'd12};
    tbl[8] = '{4'b0000, 4'b0000, 64'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 16'd0};
    tbl[9] = '{4'b0000, 4'b0000, 64'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 16'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_accept", accept, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_sum", sum, 0);
`ifdef SUM_SCHED_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    foreach (tbl[i]) begin
      req = tbl[i].req;
      valid = tbl[i].valid;
      data = tbl[i].d;
      #1;
      chk($sformatf("t%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("t%0d_accept", i), accept, tbl[i].acc);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("t%0d_done", i), done, tbl[i].done);
      if (tbl[i].done) chk($sformatf("t%0d_done_id", i), done_id, tbl[i].id);
      chk($sformatf("t%0d_sum", i), sum, tbl[i].sum);
      tick();
    end

    send(2, '{16'hFFFF, 16'd2, 16'd0, 16'd0}, 3, 0, 1'b0, 16'h0001);
    send(2, '{16'd3, 16'd0, 16'd0, 16'd0}, 2, 0, 1'b0, 16'd3);
    send(1, '{16'd4, 16'd4, 16'd0, 16'd0}, 3, 3, 1'b1, 16'd8);

    req = 4'b0001;
    tick();
    req = '0;
    valid = 4'b0001;
    data = 64'd10;
    tick();
    data = 64'd20;
    tick();
    valid = '0;
    data = '0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    repeat (2) begin
      tick();
      chk("mid_rst_done", done, 0);
    end
    rst = 1'b0;
    send(0, '{16'd3, 16'd0, 16'd0, 16'd0}, 2, 0, 1'b0, 16'd3);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1 chk("rr_idle_gnt", gnt, 0);
      tick();
      chk($sformatf("rr%0d_gnt", n), gnt, 64'(1 << (n % 4)));
      valid = 4'hF;
      data = {4{16'd1}};
      #1 chk($sformatf("rr%0d_accept1", n), accept, 64'(1 << (n % 4)));
      tick();
      data = '0;
      #1 chk($sformatf("rr%0d_accept0", n), accept, 64'(1 << (n % 4)));
      tick();
      valid = '0;
      #1;
      chk($sformatf("rr%0d_done", n), done, 1);
      chk($sformatf("rr%0d_done_id", n), done_id, 64'(n % 4));
      chk($sformatf("rr%0d_sum", n), sum, 1);
      tick();
    end
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
